// File: rtl/wbs_spi_pkg.sv
// wbs_spi_pkg: shared definitions for the Wishbone-to-SPI-master block.
// Holds the register word addresses, the STATUS/CTRL bit positions and the
// transfer FSM state encoding used by wbs_spi and spi_shift8.
package wbs_spi_pkg;

  // Register word addresses.
  localparam logic [3:0] ADR_DATA   = 4'd0;
  localparam logic [3:0] ADR_STATUS = 4'd1;
  localparam logic [3:0] ADR_CTRL   = 4'd2;

  // STATUS bit positions.
  localparam int STAT_BUSY = 0;
  localparam int STAT_RXV  = 1;
  localparam int STAT_OVR  = 2;

  // CTRL bit positions.
  localparam int CTRL_SS_HOLD = 0;
  localparam int CTRL_IRQ_EN  = 1;

  // Transfer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_shift8.sv
// spi_shift8: SPI mode-0 byte engine (MSB first).
// Holds the transfer FSM, the half-period divider, the half-period/bit
// counter, the shift register and the SCK/MOSI registers.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle request; only honoured in ST_IDLE
//   tx         byte to send, captured on start
//   miso       serial input, already synchronized
//   sck, mosi  registered serial clock / data out
//   done       high for the last HOLD cycle; rx is final during it
//   rx         shift register contents (received byte once done)
//   state      current FSM state, for busy/ss_n decode and debug
//
// Handshake: start is a single-cycle pulse accepted only while state is
// ST_IDLE; done is a single-cycle pulse, and the FSM is back in ST_IDLE on
// the edge that ends the done cycle.
module spi_shift8
  import wbs_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx,
  output spi_state_e state
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div;    // cycles spent in the current half period
  logic [3:0] half;   // half-period index inside SHIFT; bit index = half[3:1]
  logic [7:0] sh;
  logic       half_end;

  assign half_end = (div == DIV_LAST);
  assign done     = (state == ST_HOLD) && half_end;
  assign rx       = sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      div   <= '0;
      half  <= '0;
      sh    <= '0;
      sck   <= 1'b0;
      mosi  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SETUP;
            div   <= '0;
            half  <= '0;
            sh    <= tx;
            mosi  <= tx[7];
          end
        end
        ST_SETUP: begin
          if (half_end) begin
            // First rising edge: sample MISO while bit7 is on MOSI.
            div   <= '0;
            state <= ST_SHIFT;
            sck   <= 1'b1;
            sh    <= {sh[6:0], miso};
          end else begin
            div <= div + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (half_end) begin
            div  <= '0;
            half <= half + 4'd1;
            if (half == 4'd15) begin
              state <= ST_HOLD;
            end else if (half[0]) begin
              // End of a low half: rising edge, sample MISO.
              sck <= 1'b1;
              sh  <= {sh[6:0], miso};
            end else begin
              // End of a high half: falling edge. After the eighth bit
              // MOSI is left alone so it holds the last bit sent.
              sck <= 1'b0;
              if (half != 4'd14) mosi <= sh[7];
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        ST_HOLD: begin
          if (half_end) begin
            div   <= '0;
            state <= ST_IDLE;
          end else begin
            div <= div + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wbs_spi.sv
// wbs_spi: Wishbone B4 pipelined slave acting as an SPI mode-0 master.
// Software writes a byte to DATA, it is shifted out on MOSI while MISO is
// captured; the received byte and status are then readable.
//
// Registers (word address): 0 DATA, 1 STATUS {overrun, rx_valid, busy},
// 2 CTRL {irq_en, ss_hold}. Other addresses read 0, writes ignored.
//
// Ports: wbs_* Wishbone slave (clock wbs_clk_i, sync active-high reset
// wbs_rst_i), spi_sck/spi_mosi/spi_miso/spi_ss_n SPI master pins, and,
// when WBS_SPI_IRQ_EN is defined, irq_o = irq_en & (rx_valid | overrun).
//
// Handshake: a request is accepted on a cycle with cyc & stb & !stall;
// ack is asserted exactly one cycle later with dat_o valid alongside it.
// Stall is only raised for a DATA write while a transfer is running.
module wbs_spi
  import wbs_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        wbs_clk_i,
  input  logic        wbs_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_stall_o,
  output logic        wbs_ack_o,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_ss_n
`ifdef WBS_SPI_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  spi_state_e  state;
  logic        done;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_q;
  logic        rx_valid;
  logic        overrun;
  logic        ss_hold;
  logic        ss_hold_d;
  logic        irq_en;
  logic        busy;
  logic        req;
  logic        accept;
  logic        start;
  logic        data_rd;
  logic        ctrl_wr;
  logic        ovr_clr;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

  assign busy        = (state != ST_IDLE);
  assign req         = wbs_cyc_i & wbs_stb_i;
  assign wbs_stall_o = busy & req & wbs_we_i & (wbs_adr_i == ADR_DATA);
  assign accept      = req & ~wbs_stall_o;

  assign start   = accept & wbs_we_i & (wbs_adr_i == ADR_DATA) & wbs_sel_i[0];
  assign data_rd = accept & ~wbs_we_i & (wbs_adr_i == ADR_DATA);
  assign ctrl_wr = accept & wbs_we_i & (wbs_adr_i == ADR_CTRL) & wbs_sel_i[0];
  assign ovr_clr = accept & wbs_we_i & (wbs_adr_i == ADR_STATUS) & wbs_sel_i[0]
                   & wbs_dat_i[STAT_OVR];

  // Value ss_hold will hold after this edge, so ss_n tracks a CTRL write
  // on the very next cycle.
  assign ss_hold_d = ctrl_wr ? wbs_dat_i[CTRL_SS_HOLD] : ss_hold;

  spi_shift8 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk   (wbs_clk_i),
    .rst   (wbs_rst_i),
    .start (start),
    .tx    (wbs_dat_i[7:0]),
    .miso  (spi_miso),
    .sck   (spi_sck),
    .mosi  (spi_mosi),
    .done  (done),
    .rx    (rx_sh),
    .state (state)
  );

  always_comb begin
    rd_word = '0;
    case (wbs_adr_i)
      ADR_DATA:   rd_word[7:0] = rx_q;
      ADR_STATUS: begin
        rd_word[STAT_BUSY] = busy;
        rd_word[STAT_RXV]  = rx_valid;
        rd_word[STAT_OVR]  = overrun;
      end
      ADR_CTRL: begin
        rd_word[CTRL_SS_HOLD] = ss_hold;
        rd_word[CTRL_IRQ_EN]  = irq_en;
      end
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      wbs_dat_o <= '0;
      wbs_ack_o <= 1'b0;
      rx_q      <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      ss_hold   <= 1'b0;
      spi_ss_n  <= 1'b1;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept & ~wbs_we_i) ? rd_word : 32'd0;

      if (ovr_clr) overrun <= 1'b0;
      // Completion wins over a same-cycle DATA read: the read gets the old
      // byte and the new one stays valid.
      if (done) begin
        rx_q     <= rx_sh;
        rx_valid <= 1'b1;
        if (rx_valid) overrun <= 1'b1;
      end else if (data_rd) begin
        rx_valid <= 1'b0;
      end

      if (ctrl_wr) ss_hold <= wbs_dat_i[CTRL_SS_HOLD];

      if (start)                    spi_ss_n <= 1'b0;
      else if (done || !busy)       spi_ss_n <= ~ss_hold_d;
    end
  end

`ifdef WBS_SPI_IRQ_EN
  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      irq_o <= irq_en & (rx_valid | overrun);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: doc/wbs_spi.md
# wbs_spi

Wishbone B4 pipelined slave that acts as an SPI mode-0 master, the initiator counterpart to the SPI-slave bridge that drives our Wishbone bus. It plugs into one slave slot of the single-master interconnect. Software writes a byte, the block shifts it out on MOSI while capturing MISO, then exposes the received byte and status through registers.

## Interface
- `CLK_DIV`, default 4: half SCK period in `wbs_clk_i` cycles; legal values are 1..255.
- `wbs_clk_i`  in  1  sole clock.
- `wbs_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_cyc_i`  in  1  bus cycle, slot-select from the interconnect.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  write enable.
- `wbs_adr_i`  in  4  word address.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_dat_i`  in  32  write data.
- `wbs_dat_o`  out  32  read data, valid while `wbs_ack_o` is high.
- `wbs_stall_o`  out  1  request not accepted this cycle.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `spi_sck`  out  1  serial clock, idles low.
- `spi_mosi`  out  1  serial data out, MSB first.
- `spi_miso`  in  1  serial data in; externally synchronized.
- `spi_ss_n`  out  1  chip select, active-low.

## Operation
- A request is accepted when `wbs_cyc_i & wbs_stb_i & !wbs_stall_o`.
- Register map (all other addresses read 0 and ignore writes):
  - adr 0, DATA:
    - Write with `sel[0]` loads `dat_i[7:0]` and starts a transfer.
    - Read returns `{24'b0, rx}` and clears `rx_valid`.
  - adr 1, STATUS: bit0 `busy`, bit1 `rx_valid`, bit2 `overrun`.
    - `overrun` is sticky; writing 1 to bit2 with `sel[0]` clears it.
  - adr 2, CTRL: bit0 `ss_hold`, reset value 0.
- FSM states:
  - IDLE: SCK low; MOSI holds the last value.
  - SETUP: `ss_n` low, MOSI = bit7, wait one half period.
  - SHIFT: 16 half periods.
    - Rising edge samples MISO into the shift register LSB.
    - Falling edge drives the next MOSI bit.
    - A 4-bit counter tracks the bit index.
  - HOLD: one half period with SCK low; then `rx` ← shift register, `rx_valid` ← 1, and the FSM returns to IDLE.
- `ss_n` in IDLE equals `!ss_hold`.
- When a transfer completes with `ss_hold` = 0, `ss_n` deasserts on the HOLD→IDLE cycle.
- A CTRL write clearing `ss_hold` while idle raises `ss_n` the next cycle.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - `wbs_dat_o` 0, `wbs_ack_o` 0, `wbs_stall_o` 0.
  - `spi_sck` 0, `spi_mosi` 0, `spi_ss_n` 1.
  - `rx` 0, `rx_valid` 0, `overrun` 0, `ss_hold` 0, FSM in IDLE.
- `wbs_ack_o` rises exactly one cycle after acceptance; back-to-back accepts give back-to-back acks.
- `wbs_stall_o` is high only while `busy` and the presented request is a DATA write. Reads and other writes are never stalled.
- A transfer lasts 18·`CLK_DIV` cycles from the DATA-write accept cycle to IDLE:
  - SETUP lasts `CLK_DIV`.
  - SHIFT lasts 16·`CLK_DIV`.
  - HOLD lasts `CLK_DIV`.
- Completion with `rx_valid` already 1 overwrites `rx` and sets `overrun`.
- DATA read in the same cycle as completion:
  - The read returns the old `rx`.
  - `rx_valid` ends at 1.
  - `overrun` is set if the old byte was unread before that read.
- Reset mid-transfer aborts the transfer immediately: all outputs take their reset values on the next edge and no `rx` update occurs.

## Configuration
- `WBS_SPI_IRQ_EN`:
  - Defined: adds output port `irq_o` (1 bit), registered, equal to `rx_valid | overrun`, reset 0. Adds CTRL bit1 `irq_en`, reset 0, which gates `irq_o`.
  - Undefined: no `irq_o` port; CTRL bit1 reads 0 and ignores writes.

## Structure
- Package `wbs_spi_pkg`: register address constants (`ADR_DATA`, `ADR_STATUS`, `ADR_CTRL`), STATUS/CTRL bit indices, FSM state enum.
- Sub-module `spi_shift8`: half-period divider counter, bit counter, shift register, SCK/MOSI generation. It has start/done handshake and an 8-bit tx in / rx out.
- The top level holds the bus decode, registers, stall/ack and `ss_n` logic.

## Test plan
With `CLK_DIV`=2 unless stated:
- Reset, then idle 10 cycles → `ss_n`=1, `sck`=0, STATUS reads 0.
- Write DATA 0xA5 with MISO looped to MOSI →
  - MOSI sequence is 1,0,1,0,0,1,0,1.
  - There are 8 SCK rising edges.
  - `busy` clears 36 cycles after the accept cycle.
  - DATA reads 0xA5.
  - `rx_valid` then clears.
- Second DATA write issued while busy → stall held until IDLE, then accepted and acked one cycle later; no byte is lost.
- Two transfers without reading DATA → `overrun`=1 and DATA = second byte; writing STATUS 0x4 clears `overrun`.
- `ss_hold`=1 with two transfers → `ss_n` stays 0 between bytes; clearing `ss_hold` makes `ss_n`=1 one cycle later.
- Reset asserted at bit 3 of a transfer → next cycle `sck`=0, `ss_n`=1, `rx_valid`=0; a new transfer then works.
